// File: rtl/bky_shift_ctrl.sv
// Buckeye serial configuration engine: shifts one 48-bit word into each
// unmasked chip over AMPIN/AMPCLK and captures the old word from AMPOUT.
module bky_shift_ctrl #(
  parameter int unsigned HALF = 2
) (
  input  logic        CMSCLK,
  input  logic        RST_B,
  input  logic        WR_EN,
  input  logic [2:0]  WR_ADDR,
  input  logic [47:0] WR_DATA,
  input  logic [2:0]  RD_ADDR,
  output logic [47:0] RD_DATA,
  input  logic [5:0]  MASK,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic [5:0]  AMPIN,
  output logic [5:0]  AMPCLK,
  input  logic [5:0]  AMPOUT
);

  localparam int unsigned NCHIP  = 6;
  localparam int unsigned WORD_W = 48;
  localparam int unsigned BIT_W  = 6;
  localparam int unsigned PH_W   = 4;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic [NCHIP-1:0]        msk_q, msk_d;
  logic                    capture;
  logic                    wr_ok;
  logic                    busy_d, done_d;
  logic [NCHIP-1:0]        ampin_d, ampclk_d;
  logic [WORD_W-1:0]       cfg_q [NCHIP];
  logic [WORD_W-1:0]       rb_q  [NCHIP];

  // Writes land only when no shift is running or about to report done.
  assign wr_ok = WR_EN && !BUSY && (state_q == S_IDLE);

  // State, bit and phase registers.
  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      ph_q    <= '0;
      msk_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      msk_q   <= msk_d;
    end
  end

  // Next state, counters and registered-output next values.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    ph_d     = ph_q;
    msk_d    = msk_q;
    capture  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ampin_d  = '0;
    ampclk_d = '0;

    unique case (state_q)
      S_IDLE: begin
        // DONE high means the previous shift is still reporting; ignore START.
        if (START && !DONE) begin
          msk_d   = MASK;
          bit_d   = '0;
          ph_d    = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          capture = 1'b1;
          state_d = S_HIGH;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_HIGH: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = S_FIN;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = S_LOW;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pins follow the state one cycle later, so they change on clean edges.
    busy_d   = (state_q == S_LOW) || (state_q == S_HIGH);
    done_d   = (state_q == S_FIN);
    ampclk_d = (state_q == S_HIGH) ? msk_q : '0;
    for (int n = 0; n < NCHIP; n++) begin
      ampin_d[n] = busy_d && msk_q[n] && cfg_q[n][bit_q];
    end
  end

  // Registered status and chip-facing outputs.
  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      AMPIN  <= '0;
      AMPCLK <= '0;
    end else begin
      BUSY   <= busy_d;
      DONE   <= done_d;
      AMPIN  <= ampin_d;
      AMPCLK <= ampclk_d;
    end
  end

  // Config words from the host and readback words shifted in from AMPOUT.
  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int n = 0; n < NCHIP; n++) begin
        cfg_q[n] <= '0;
        rb_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NCHIP; n++) begin
        if (wr_ok && (WR_ADDR == 3'(n + 1))) begin
          cfg_q[n] <= WR_DATA;
        end
        if (capture && msk_q[n]) begin
          rb_q[n] <= {AMPOUT[n], rb_q[n][WORD_W-1:1]};
        end
      end
    end
  end

  // Readback mux; addresses 0 and 7 read as zero.
  always_comb begin
    RD_DATA = '0;
    for (int n = 0; n < NCHIP; n++) begin
      if (RD_ADDR == 3'(n + 1)) begin
        RD_DATA = rb_q[n];
      end
    end
  end

endmodule

// File: tb/tb_bky_shift_ctrl.sv
// Bench for bky_shift_ctrl: six chip shift-register models on the pins,
// a model of CFG/RB/chip contents, and a queue-fed monitor.
module tb_bky_shift_ctrl;

  localparam int unsigned H = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [47:0] wr_data;
  logic [2:0]  rd_addr;
  logic [47:0] rd_data;
  logic [5:0]  mask;
  logic        start;
  logic        busy, done;
  logic [5:0]  ampin, ampclk, ampout;

  // second instance with HALF=1
  logic        b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [47:0] b_wr_data;
  logic [2:0]  b_rd_addr;
  logic [47:0] b_rd_data;
  logic [5:0]  b_mask;
  logic        b_start;
  logic        b_busy, b_done;
  logic [5:0]  b_ampin, b_ampclk, b_ampout;

  always #5 clk = ~clk;

  bky_shift_ctrl #(.HALF(H)) dut (
    .CMSCLK(clk), .RST_B(rst_b), .WR_EN(wr_en), .WR_ADDR(wr_addr),
    .WR_DATA(wr_data), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .MASK(mask),
    .START(start), .BUSY(busy), .DONE(done), .AMPIN(ampin),
    .AMPCLK(ampclk), .AMPOUT(ampout)
  );

  bky_shift_ctrl #(.HALF(1)) dut1 (
    .CMSCLK(clk), .RST_B(rst_b), .WR_EN(b_wr_en), .WR_ADDR(b_wr_addr),
    .WR_DATA(b_wr_data), .RD_ADDR(b_rd_addr), .RD_DATA(b_rd_data), .MASK(b_mask),
    .START(b_start), .BUSY(b_busy), .DONE(b_done), .AMPIN(b_ampin),
    .AMPCLK(b_ampclk), .AMPOUT(b_ampout)
  );

  function automatic logic [47:0] chip_init(input int n);
    return 48'hC0DE_0000_0000 | 48'(n + 1);
  endfunction

  // Chip models: 48-bit right shifters clocked by AMPCLK.
  logic [47:0] chip_w [6];
  for (genvar g = 0; g < 6; g++) begin : g_chip
    logic [47:0] sh;
    initial sh = chip_init(g);
    always @(posedge ampclk[g]) sh <= {ampin[g], sh[47:1]};
    assign ampout[g]  = sh[0];
    assign chip_w[g]  = sh;
  end

  logic [47:0] c1;
  initial c1 = 48'h1357_9BDF_2468;
  always @(posedge b_ampclk[0]) c1 <= {b_ampin[0], c1[47:1]};
  assign b_ampout = {5'b0, c1[0]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model of the design contents.
  logic [47:0] m_cfg [6];
  logic [47:0] m_chip[6];
  logic [47:0] m_rb  [6];

  typedef struct packed {
    logic [31:0]      k;
    logic [5:0]       msk;
    logic [5:0][47:0] chip;
  } shexp_t;

  shexp_t      sh_q[$];
  logic [31:0] k1_q[$];
  logic [47:0] rd_q[$];
  logic        rd_vld = 1'b0;

  task automatic model_push(input logic [5:0] m, input int k);
    shexp_t r;
    for (int n = 0; n < 6; n++) begin
      if (m[n]) begin
        m_rb[n]   = m_chip[n];
        m_chip[n] = m_cfg[n];
      end
      r.chip[n] = m_chip[n];
    end
    r.k   = 32'(k);
    r.msk = m;
    sh_q.push_back(r);
  endtask

  // Monitor for the HALF=2 instance.
  initial begin : mon
    int       busy_cnt;
    int       edges[6];
    logic [5:0] clk_prev;
    logic [5:0] ampin_seen;
    logic     done_prev;
    shexp_t   r;
    busy_cnt = 0; clk_prev = '0; ampin_seen = '0; done_prev = 1'b0;
    for (int n = 0; n < 6; n++) edges[n] = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        busy_cnt = 0; clk_prev = '0; ampin_seen = '0; done_prev = 1'b0;
        for (int n = 0; n < 6; n++) edges[n] = 0;
      end else begin
        if (done_prev) chk("done_single_pulse", 48'(done), 48'd0);
        done_prev = done;
        if (busy) busy_cnt++;
        for (int n = 0; n < 6; n++) if (ampclk[n] && !clk_prev[n]) edges[n]++;
        clk_prev   = ampclk;
        ampin_seen = ampin_seen | ampin;
        if (rd_vld) begin
          if (rd_q.size() == 0) chk("rd_queue_empty", 48'd1, 48'd0);
          else chk($sformatf("rd_addr%0d", rd_addr), rd_data, rd_q.pop_front());
        end
        if (done) begin
          if (sh_q.size() == 0) begin
            chk("unexpected_done", 48'd1, 48'd0);
          end else begin
            r = sh_q.pop_front();
            chk("done_latency", 48'(cyc - int'(r.k)), 48'(96 * H + 1));
            chk("busy_cycles", 48'(busy_cnt), 48'(96 * H));
            chk("busy_at_done", 48'(busy), 48'd0);
            chk("masked_ampin", 48'(ampin_seen & ~r.msk), 48'd0);
            for (int n = 0; n < 6; n++) begin
              chk($sformatf("edges_chip%0d", n + 1), 48'(edges[n]), r.msk[n] ? 48'd48 : 48'd0);
              chk($sformatf("chip%0d_word", n + 1), chip_w[n], r.chip[n]);
            end
          end
          busy_cnt = 0; ampin_seen = '0;
          for (int n = 0; n < 6; n++) edges[n] = 0;
        end
      end
    end
  end

  // Monitor for the HALF=1 instance (chip 1 only).
  initial begin : mon1
    int       busy_cnt;
    int       edges;
    logic     clk_prev;
    logic [31:0] k;
    busy_cnt = 0; edges = 0; clk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        if (b_busy) busy_cnt++;
        if (b_ampclk[0] && !clk_prev) edges++;
        clk_prev = b_ampclk[0];
        if (b_done) begin
          if (k1_q.size() == 0) begin
            chk("h1_unexpected_done", 48'd1, 48'd0);
          end else begin
            k = k1_q.pop_front();
            chk("h1_done_latency", 48'(cyc - int'(k)), 48'd97);
            chk("h1_busy_cycles", 48'(busy_cnt), 48'd96);
            chk("h1_edges", 48'(edges), 48'd48);
            chk("h1_chip1_word", c1, 48'hDEAD_BEEF_0001);
          end
          busy_cnt = 0; edges = 0;
        end
      end
    end
  end

  task automatic write_cfg(input logic [2:0] a, input logic [47:0] d);
    @(negedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (a >= 3'd1 && a <= 3'd6) m_cfg[a - 3'd1] = d;
    @(negedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_shift(input logic [5:0] m);
    @(negedge clk); #1;
    mask = m; start = 1'b1;
    model_push(m, cyc + 1);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!done) chk("done_timeout", 48'd0, 48'd1);
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [47:0] e);
    @(negedge clk); #1;
    rd_addr = a; rd_vld = 1'b1;
    rd_q.push_back(e);
    @(negedge clk); #1;
    rd_vld = 1'b0;
  endtask

  task automatic rd_all();
    for (int n = 0; n < 6; n++) rd_chk(3'(n + 1), m_rb[n]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_b = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = 3'd1;
    mask = '0; start = 1'b0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = 3'd1;
    b_mask = '0; b_start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      m_cfg[n] = '0; m_rb[n] = '0; m_chip[n] = chip_init(n);
    end
    repeat (3) @(negedge clk);
    chk("rst_busy",   48'(busy),   48'd0);
    chk("rst_done",   48'(done),   48'd0);
    chk("rst_ampin",  48'(ampin),  48'd0);
    chk("rst_ampclk", 48'(ampclk), 48'd0);
    chk("rst_rd_data", rd_data,    48'd0);
    #1 rst_b = 1'b1;

    // Pass 1: small words into all chips; RB gets the power-up chip contents.
    for (int n = 1; n <= 6; n++) write_cfg(3'(n), 48'(n));
    start_shift(6'h3F);
    wait_done(400);
    rd_all();
    rd_chk(3'd0, 48'd0);
    rd_chk(3'd7, 48'd0);

    // Pass 2: RB returns the pass-1 words.
    for (int n = 1; n <= 6; n++) write_cfg(3'(n), 48'hA5A5_A5A5_A5A5);
    start_shift(6'h3F);
    wait_done(400);
    rd_all();

    // Pass 3: chips 1 and 3 only; mid-shift START and write are dropped.
    for (int n = 1; n <= 6; n++) write_cfg(3'(n), 48'h5A5A_0000_0000 | 48'(n));
    start_shift(6'b000101);
    repeat (50) @(negedge clk);
    #1 start = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 48'hFFFF_FFFF_FFFF;
    @(negedge clk); #1 start = 1'b0; wr_en = 1'b0;
    wait_done(400);
    rd_all();

    // Pass 4: write and START together; chip 2 must get the earlier word.
    @(negedge clk); #1;
    mask = 6'h3F; start = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 48'h0123_4567_89AB;
    m_cfg[3] = 48'h0123_4567_89AB;
    model_push(6'h3F, cyc + 1);
    @(negedge clk); #1 start = 1'b0; wr_en = 1'b0;
    wait_done(400);

    // START held through the DONE cycle: only the second sample starts a shift.
    #1 start = 1'b1;
    @(negedge clk); #1;
    k = cyc + 1;
    @(negedge clk);
    chk("start_in_done_ignored", 48'(busy), 48'd0);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_after_done_taken", 48'(busy), 48'd1);

    // Reset during bit 20 low phase of that shift.
    while (cyc < k + 82) @(negedge clk);
    #1 rst_b = 1'b0;
    rd_addr = 3'd1;
    #1;
    chk("midrst_busy",    48'(busy),   48'd0);
    chk("midrst_done",    48'(done),   48'd0);
    chk("midrst_ampin",   48'(ampin),  48'd0);
    chk("midrst_ampclk",  48'(ampclk), 48'd0);
    chk("midrst_rd_data", rd_data,     48'd0);
    for (int n = 0; n < 6; n++) begin
      m_chip[n] = {m_chip[n][19:0], m_chip[n][47:20]};
      m_cfg[n]  = '0;
      m_rb[n]   = '0;
    end
    @(negedge clk); @(negedge clk);
    #1 rst_b = 1'b1;

    // Fresh shift after reset: zeros go out, rotated partial words come back.
    start_shift(6'h3F);
    wait_done(400);
    rd_all();

    // HALF=1 instance.
    @(negedge clk); #1;
    b_wr_en = 1'b1; b_wr_addr = 3'd1; b_wr_data = 48'hDEAD_BEEF_0001;
    @(negedge clk); #1;
    b_wr_en = 1'b0; b_mask = 6'b000001; b_start = 1'b1;
    k1_q.push_back(32'(cyc + 1));
    @(negedge clk); #1 b_start = 1'b0;
    begin
      int c = 0;
      while (!b_done && c < 200) begin
        @(negedge clk);
        c++;
      end
      if (!b_done) chk("h1_done_timeout", 48'd0, 48'd1);
    end
    #1 b_rd_addr = 3'd1;
    #1 chk("h1_rb1", b_rd_data, 48'h1357_9BDF_2468);

    repeat (3) @(negedge clk);
    if (sh_q.size() != 0) chk("sh_queue_left", 48'(sh_q.size()), 48'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
